// File: rtl/bcd_change_dispenser.sv
// Change-return engine: subtracts the BCD price from the BCD credit, then pays the
// difference out coin by coin (largest coin first) over a req/ack handshake.
module bcd_change_dispenser #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic [3:0]       credit_tens,
    input  logic [3:0]       credit_ones,
    input  logic [3:0]       price_tens,
    input  logic [3:0]       price_ones,
    input  logic             coin_ack,
    output logic             coin_req,
    output logic [1:0]       coin_sel,
    output logic [3:0]       bal_tens,
    output logic [3:0]       bal_ones,
    output logic [CNT_W-1:0] coins_out,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [1:0]       err_code
);

    typedef enum logic [2:0] {S_IDLE, S_SUB, S_SEL, S_REQ, S_DONE, S_FAULT} state_t;

    localparam logic [1:0] SEL_1  = 2'd0;
    localparam logic [1:0] SEL_5  = 2'd1;
    localparam logic [1:0] SEL_10 = 2'd2;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CREDIT  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_BCD     = 2'd3;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [3:0]       ct_q, ct_d, co_q, co_d, pt_q, pt_d, po_q, po_d;
    logic [3:0]       bal_t_q, bal_t_d, bal_o_q, bal_o_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       err_q, err_d;
    logic [CNT_W-1:0] coins_q, coins_d;
    logic [7:0]       timer_q, timer_d;

    logic       digits_ok;
    logic [4:0] ones_diff, tens_diff;
    logic       borrow;
    logic [3:0] ones_fix;

    assign digits_ok = (credit_tens <= 4'd9) && (credit_ones <= 4'd9) &&
                       (price_tens  <= 4'd9) && (price_ones  <= 4'd9);

    // Digit-wise subtract in 5 bits so bit 4 acts as the sign/borrow.
    always_comb begin
        ones_diff = {1'b0, co_q} - {1'b0, po_q};
        borrow    = ones_diff[4];
        ones_fix  = borrow ? (ones_diff[3:0] + 4'd10) : ones_diff[3:0];
        tens_diff = {1'b0, ct_q} - {1'b0, pt_q} - {4'd0, borrow};
    end

    always_comb begin
        // NOTE: every target gets a hold value first so no path can infer a latch.
        state_d = state_q;
        ct_d    = ct_q;
        co_d    = co_q;
        pt_d    = pt_q;
        po_d    = po_q;
        bal_t_d = bal_t_q;
        bal_o_d = bal_o_q;
        sel_d   = sel_q;
        err_d   = err_q;
        coins_d = coins_q;
        timer_d = timer_q;

        if (clear) begin
            state_d = S_IDLE;
            bal_t_d = '0;
            bal_o_d = '0;
            sel_d   = '0;
            err_d   = ERR_NONE;
            coins_d = '0;
            timer_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: if (start) begin
                    ct_d    = credit_tens;
                    co_d    = credit_ones;
                    pt_d    = price_tens;
                    po_d    = price_ones;
                    coins_d = '0;
                    err_d   = digits_ok ? ERR_NONE : ERR_BCD;
                    state_d = digits_ok ? S_SUB : S_FAULT;
                end
                S_SUB: begin
                    if (tens_diff[4]) begin
                        err_d   = ERR_CREDIT;
                        state_d = S_FAULT;
                    end else begin
                        bal_t_d = tens_diff[3:0];
                        bal_o_d = ones_fix;
                        state_d = S_SEL;
                    end
                end
                S_SEL: begin
                    timer_d = '0;
                    if (bal_t_q == 4'd0 && bal_o_q == 4'd0) begin
                        state_d = S_DONE;
                    end else begin
                        if (bal_t_q != 4'd0)      sel_d = SEL_10;
                        else if (bal_o_q >= 4'd5) sel_d = SEL_5;
                        else                      sel_d = SEL_1;
                        state_d = S_REQ;
                    end
                end
                S_REQ: begin
                    // An ack on the terminal timer cycle still counts as a delivered coin.
                    if (coin_ack) begin
                        unique case (sel_q)
                            SEL_10:  bal_t_d = bal_t_q - 4'd1;
                            SEL_5:   bal_o_d = bal_o_q - 4'd5;
                            default: bal_o_d = bal_o_q - 4'd1;
                        endcase
                        if (coins_q != '1) coins_d = coins_q + 1'b1;
                        state_d = S_SEL;
                    end else if (timer_q == TIMER_LAST) begin
                        err_d   = ERR_TIMEOUT;
                        state_d = S_FAULT;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
                S_DONE: begin
                    bal_t_d = '0;
                    bal_o_d = '0;
                    state_d = S_IDLE;
                end
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ct_q    <= '0;
            co_q    <= '0;
            pt_q    <= '0;
            po_q    <= '0;
            bal_t_q <= '0;
            bal_o_q <= '0;
            sel_q   <= '0;
            err_q   <= ERR_NONE;
            coins_q <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            ct_q    <= ct_d;
            co_q    <= co_d;
            pt_q    <= pt_d;
            po_q    <= po_d;
            bal_t_q <= bal_t_d;
            bal_o_q <= bal_o_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            coins_q <= coins_d;
            timer_q <= timer_d;
        end
    end

    assign coin_req  = (state_q == S_REQ);
    assign coin_sel  = sel_q;
    assign bal_tens  = bal_t_q;
    assign bal_ones  = bal_o_q;
    assign coins_out = coins_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign fault     = (state_q == S_FAULT);
    assign err_code  = err_q;

endmodule

// File: tb/tb_bcd_change_dispenser.sv
// Directed bench for bcd_change_dispenser: a vector table of whole transactions plus
// hand-written sequences for timeout, clear and reset corner cases.
module tb_bcd_change_dispenser;

    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned CNT_W   = 5;

    logic             clk = 1'b0;
    logic             rst_n, start, clear, coin_ack;
    logic [3:0]       credit_tens, credit_ones, price_tens, price_ones;
    logic             coin_req, busy, done, fault;
    logic [1:0]       coin_sel, err_code;
    logic [3:0]       bal_tens, bal_ones;
    logic [CNT_W-1:0] coins_out;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bcd_change_dispenser #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .credit_tens(credit_tens), .credit_ones(credit_ones),
        .price_tens(price_tens), .price_ones(price_ones),
        .coin_ack(coin_ack), .coin_req(coin_req), .coin_sel(coin_sel),
        .bal_tens(bal_tens), .bal_ones(bal_ones), .coins_out(coins_out),
        .busy(busy), .done(done), .fault(fault), .err_code(err_code)
    );

    typedef struct {
        logic [3:0]  ct, co, pt, po;
        logic [7:0]  chg;     // expected change, BCD
        int          n;       // expected coin count
        logic [31:0] seq;     // expected coin_sel of coin i at bits [2i+1:2i]
        logic [1:0]  err;
        int          first;   // cycle after the start edge where req/done/fault first shows
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_req"},   32'(coin_req), 0);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_sel"},   32'(coin_sel), 0);
        check({tag, "_bal"},   {24'd0, bal_tens, bal_ones}, 0);
        check({tag, "_coins"}, 32'(coins_out), 0);
        check({tag, "_flags"}, {29'd0, done, fault, 1'b0}, 0);
        check({tag, "_err"},   32'(err_code), 0);
    endtask

    task automatic pulse_clear();
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int         first = -1;
        int         ncoins = 0;
        int         ndone = 0;
        bit         ended = 1'b0;
        logic [7:0] bal_exp = v.chg;
        logic [1:0] es;
        @(negedge clk);
        {credit_tens, credit_ones, price_tens, price_ones} = {v.ct, v.co, v.pt, v.po};
        start = 1'b1;
        for (int cyc = 1; cyc <= 120 && !ended; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (first < 0 && (coin_req || done || fault)) first = cyc;
            if (ndone != 0) begin
                check({tag, "_done_pulse"}, 32'(done), 0);
                check({tag, "_busy_after"}, 32'(busy), 0);
                ended = 1'b1;
            end else if (fault) begin
                ended = 1'b1;
            end else begin
                if (coin_req) begin
                    es = (ncoins < 16) ? v.seq[2*ncoins +: 2] : 2'd0;
                    check({tag, "_sel"}, 32'(coin_sel), 32'(es));
                    check({tag, "_bal"}, {24'd0, bal_tens, bal_ones}, 32'(bal_exp));
                    case (es)
                        2'd2:    bal_exp[7:4] = bal_exp[7:4] - 4'd1;
                        2'd1:    bal_exp[3:0] = bal_exp[3:0] - 4'd5;
                        default: bal_exp[3:0] = bal_exp[3:0] - 4'd1;
                    endcase
                    ncoins++;
                    coin_ack = 1'b1;
                end else begin
                    coin_ack = 1'b0;
                end
                if (done) begin
                    ndone++;
                    check({tag, "_coins_out"}, 32'(coins_out), 32'(v.n));
                    check({tag, "_bal_done"}, {24'd0, bal_tens, bal_ones}, 0);
                    check({tag, "_err_done"}, 32'(err_code), 0);
                end
            end
        end
        coin_ack = 1'b0;
        check({tag, "_finished"}, 32'(ended), 1);
        check({tag, "_latency"}, 32'(first), 32'(v.first));
        check({tag, "_ncoins"}, 32'(ncoins), 32'(v.n));
        if (v.err == 2'd0) begin
            check({tag, "_ndone"}, 32'(ndone), 1);
        end else begin
            check({tag, "_fault"}, 32'(fault), 1);
            check({tag, "_err"}, 32'(err_code), 32'(v.err));
            check({tag, "_bal_fault"}, {24'd0, bal_tens, bal_ones}, 0);
            @(negedge clk); start = 1'b1;        // ignored while faulted
            @(negedge clk); start = 1'b0;
            check({tag, "_fault_hold"}, {30'd0, fault, busy}, 3);
            pulse_clear();
            check_idle_zero({tag, "_clr"});
        end
    endtask

    task automatic wait_req(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            start = 1'b0;
            seen = coin_req;
        end
        check({tag, "_req_seen"}, 32'(seen), 1);
    endtask

    initial begin
        int  reqc;
        bit  seen;
        vecs[0] = '{4'd2, 4'd7, 4'd1, 4'd5, 8'h12, 3,  32'h2,     2'd0, 3};
        vecs[1] = '{4'd2, 4'd0, 4'd1, 4'd2, 8'h08, 4,  32'h1,     2'd0, 3};
        vecs[2] = '{4'd0, 4'd5, 4'd0, 4'd7, 8'h00, 0,  32'h0,     2'd1, 2};
        vecs[3] = '{4'd1, 4'hC, 4'd0, 4'd0, 8'h00, 0,  32'h0,     2'd3, 1};
        vecs[4] = '{4'd1, 4'd5, 4'd1, 4'd5, 8'h00, 0,  32'h0,     2'd0, 3};
        vecs[5] = '{4'd9, 4'd9, 4'd0, 4'd0, 8'h99, 14, 32'h6AAAA, 2'd0, 3};
        vecs[6] = '{4'd1, 4'd0, 4'd0, 4'd0, 8'h10, 1,  32'h2,     2'd0, 3};
        vecs[7] = '{4'd0, 4'd0, 4'd0, 4'd1, 8'h00, 0,  32'h0,     2'd1, 2};
        vecs[8] = '{4'd3, 4'd0, 4'hA, 4'd0, 8'h00, 0,  32'h0,     2'd3, 1};
        vecs[9] = '{4'd5, 4'd0, 4'd4, 4'd5, 8'h05, 1,  32'h1,     2'd0, 3};

        rst_n = 1'b0; start = 1'b0; clear = 1'b0; coin_ack = 1'b0;
        {credit_tens, credit_ones, price_tens, price_ones} = '0;
        repeat (2) @(negedge clk);
        check_idle_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Hopper never acks: coin_req stays up exactly TIMEOUT cycles, then fault.
        @(negedge clk);
        {credit_tens, credit_ones, price_tens, price_ones} = {4'd1, 4'd0, 4'd0, 4'd0};
        start = 1'b1;
        reqc = 0;
        seen = 1'b0;
        for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (coin_req) begin
                reqc++;
                if (coin_sel != 2'd2) check("to_sel_stable", 32'(coin_sel), 2);
            end
            seen = fault;
        end
        check("to_req_cycles", 32'(reqc), TIMEOUT);
        check("to_fault", 32'(fault), 1);
        check("to_err", 32'(err_code), 2);
        pulse_clear();
        check_idle_zero("to_clr");

        // Ack arrives on the terminal timeout cycle: the coin is accepted.
        @(negedge clk);
        start = 1'b1;
        reqc = 0;
        seen = 1'b0;
        for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (coin_req) begin
                reqc++;
                coin_ack = (reqc == TIMEOUT);
            end else begin
                coin_ack = 1'b0;
            end
            seen = done || fault;
        end
        coin_ack = 1'b0;
        check("tack_req_cycles", 32'(reqc), TIMEOUT);
        check("tack_done", {30'd0, done, fault}, 2);
        check("tack_coins", 32'(coins_out), 1);
        @(negedge clk);
        check("tack_idle", 32'(busy), 0);

        // clear in the middle of REQ; a start while busy is ignored.
        @(negedge clk);
        {credit_tens, credit_ones, price_tens, price_ones} = {4'd2, 4'd7, 4'd1, 4'd5};
        start = 1'b1;
        wait_req("clr");
        {credit_tens, credit_ones, price_tens, price_ones} = {4'd9, 4'd9, 4'd0, 4'd0};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_start_req", 32'(coin_req), 1);
        check("busy_start_bal", {24'd0, bal_tens, bal_ones}, 32'h12);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_idle_zero("mid_clear");
        run_vec(vecs[0], "after_clear");

        // Reset in the middle of REQ.
        @(negedge clk);
        {credit_tens, credit_ones, price_tens, price_ones} = {4'd2, 4'd0, 4'd1, 4'd2};
        start = 1'b1;
        wait_req("rst");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_idle_zero("mid_reset");
        run_vec(vecs[1], "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_change_dispenser.md
Name: bcd_change_dispenser

Overview:
Change-return engine for the vending machine. It is the counterpart of the BCD credit accumulator: the accumulator adds coins into a 2-digit BCD credit, and this block takes that credit and counts it back down.
- On start it computes change = credit - price in 2-digit BCD.
- It then pays the change out coin by coin to the coin hopper over a req/ack handshake, always choosing the largest coin that fits.
- It reports done or a fault code to the top-level controller.

Parameters:
TIMEOUT, 16, max cycles coin_req may stay high without coin_ack before a fault (2..255).
CNT_W, 5, width of the coins_out counter.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  begin transaction; sampled only in IDLE
clear  input  1  synchronous abort/acknowledge; returns FSM to IDLE from any state
credit_tens  input  4  BCD tens digit of inserted credit
credit_ones  input  4  BCD ones digit of inserted credit
price_tens  input  4  BCD tens digit of item price
price_ones  input  4  BCD ones digit of item price
coin_ack  input  1  hopper has dropped the requested coin
coin_req  output  1  request one coin from the hopper
coin_sel  output  2  coin to drop: 0 = 1 unit, 1 = 5 units, 2 = 10 units (3 never driven)
bal_tens  output  4  remaining change, BCD tens
bal_ones  output  4  remaining change, BCD ones
coins_out  output  CNT_W  coins dispensed in the current transaction
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on successful completion
fault  output  1  high while in FAULT
err_code  output  2  0 = none, 1 = insufficient credit, 2 = hopper timeout, 3 = invalid BCD input

Behaviour:
Reset (rst_n=0 at an edge, any state):
- FSM goes to IDLE.
- All outputs 0: coin_req, coin_sel, bal_*, coins_out, busy, done, fault, err_code.
- Timeout counter cleared.

States: IDLE, SUB, SEL, REQ, DONE, FAULT. clear=1 forces IDLE next cycle from any state, with the same output clearing as reset. clear has priority over every other input.

IDLE:
- start=1 registers the four digits, clears coins_out and err_code, and moves to SUB.
- If any digit > 9, go to FAULT with err_code=3 instead.

SUB (one cycle):
- Digit-wise BCD subtract with borrow: ones = c_o - p_o, plus 10 and borrow if negative; tens = c_t - p_t - borrow.
- Tens negative -> FAULT, err_code=1, bal_* unchanged at 0.
- Otherwise load bal_* and go to SEL.

SEL (one cycle):
- bal = 00 -> DONE.
- Else choose a coin and go to REQ:
  - bal_tens >= 1 -> sel 2;
  - else bal_ones >= 5 -> sel 1;
  - else sel 0.
- The counter starts at 0.

REQ:
- coin_req=1. coin_sel stays stable for the entire REQ state.
- coin_ack=1:
  - subtract the coin from bal (10: tens-1; 5: ones-5; 1: ones-1 — no borrow is possible by construction);
  - coins_out+1, saturating at all-ones;
  - go to SEL, so coin_req is low for at least one cycle between coins.
- Otherwise the counter increments. Reaching TIMEOUT-1 with no ack -> FAULT, err_code=2.
- Ack and the timeout terminal count in the same cycle: ack wins.

DONE: done=1 for exactly one cycle, then IDLE. bal_* = 0; coins_out is held until the next start.

FAULT: fault=1 and err_code are held until clear. start is ignored.

Additional rules:
- coin_ack outside REQ is ignored.
- start outside IDLE is ignored.
- Latency: start sampled at edge 0 -> coin_req high after edge 3 (SUB at 1, SEL at 2, REQ at 3).
- Zero change: done high after edge 3.
- Each coin costs 1 REQ cycle (if acked immediately) plus 1 SEL cycle.

Test Plan:
1. credit 27, price 15, coin_ack returned 1 cycle after each req -> coin_sel sequence 2,0,0; bal 12->02->01->00; done pulse; coins_out=3; busy low after DONE.
2. credit 20, price 12 (tests borrow) -> bal 08 after SUB; coin sequence 1,0,0,0; coins_out=4; done once.
3. credit 05, price 07 -> fault=1, err_code=1 after edge 2, no coin_req; clear -> IDLE, fault=0.
4. TIMEOUT=8, credit 10, price 00, coin_ack held low -> coin_req high exactly 8 cycles then fault, err_code=2; coin_ack asserted on the terminal cycle instead -> coin accepted, done.
5. credit_ones=4'hC -> FAULT err_code=3 on the edge after start. Separately, credit 15 = price 15 -> done high at edge 3, coins_out=0.
6. clear in REQ mid-transaction, and rst_n=0 mid-REQ -> coin_req and busy low next cycle, all outputs 0. start during busy ignored; a new start after clear runs normally.
